// File: rtl/pipelined_div.sv
// Pipelined unsigned restoring divider: N registered stages, one quotient bit per stage, MSB first.
// Define DIV_ZERO_DET_EN to add the dz output flagging results computed from divisor == 0.
module pipelined_div #(
   parameter int unsigned N = 16,
   parameter int unsigned D = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         in_valid,
   input  logic [N-1:0] dividend,
   input  logic [D-1:0] divisor,
   output logic         out_valid,
   output logic [N-1:0] quotient,
   output logic [D-1:0] remainder
`ifdef DIV_ZERO_DET_EN
   ,
   output logic         dz
`endif
);

   // Stage 0 holds captured operands; stage k+1 holds the outcome of step k.
   logic [N:0]   vld_q;
   logic [D-1:0] rem_q [N+1];
   logic [N-1:0] quo_q [N+1];
   logic [N-1:0] dvd_q [N];
   logic [D-1:0] div_q [N];

   logic [D:0]   trial [N];
   logic [N-1:0] fits;
   logic [D-1:0] rem_d [N];
   logic [N-1:0] quo_d [N];

   always_comb begin
      fits = '0;
      for (int k = 0; k < int'(N); k++) begin
         trial[k] = {rem_q[k], dvd_q[k][N-1]};
         fits[k]  = (trial[k] >= {1'b0, div_q[k]});
         // When the trial fits, the difference is below the divisor, so D bits suffice.
         rem_d[k] = fits[k] ? D'(trial[k] - {1'b0, div_q[k]}) : trial[k][D-1:0];
         quo_d[k] = {quo_q[k][N-2:0], fits[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         for (int k = 0; k <= int'(N); k++) begin
            rem_q[k] <= '0;
            quo_q[k] <= '0;
         end
         for (int k = 0; k < int'(N); k++) begin
            dvd_q[k] <= '0;
            div_q[k] <= '0;
         end
      end else if (ce) begin
         vld_q    <= {vld_q[N-1:0], in_valid};
         rem_q[0] <= '0;
         quo_q[0] <= '0;
         dvd_q[0] <= dividend;
         div_q[0] <= divisor;
         for (int k = 0; k < int'(N); k++) begin
            rem_q[k+1] <= rem_d[k];
            quo_q[k+1] <= quo_d[k];
         end
         for (int k = 0; k < int'(N) - 1; k++) begin
            dvd_q[k+1] <= dvd_q[k] << 1;
            div_q[k+1] <= div_q[k];
         end
      end
   end

   assign out_valid = vld_q[N];
   assign quotient  = quo_q[N];
   assign remainder = rem_q[N];

`ifdef DIV_ZERO_DET_EN
   logic [N:0] dz_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         dz_q <= '0;
      end else if (ce) begin
         dz_q <= {dz_q[N-1:0], divisor == '0};
      end
   end

   assign dz = dz_q[N];
`endif

endmodule

// File: tb/tb_pipelined_div.sv
// Directed bench for pipelined_div: a latency delay-line model plus hand-computed spot checks.
module tb_pipelined_div;
   localparam int N = 16;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ce = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [D-1:0] divisor = '0;
   logic         out_valid;
   logic [N-1:0] quotient;
   logic [D-1:0] remainder;
`ifdef DIV_ZERO_DET_EN
   logic         dz;
`endif

   int total = 0;
   int bad = 0;
   int nvalid = 0;
   int mark;

   typedef struct packed {
      logic         v;
      logic [N-1:0] q;
      logic [D-1:0] r;
      logic         z;
   } exp_t;

   exp_t line [N+1];

   pipelined_div #(.N(N), .D(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef DIV_ZERO_DET_EN
      ,
      .dz        (dz)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; the model shifts on advancing edges and outputs are checked #1 later.
   task automatic tick();
      exp_t         nx;
      logic         pv;
      logic [N-1:0] pq;
      logic [D-1:0] pr;
      logic         rs;
      logic         c;
      pv = out_valid;
      pq = quotient;
      pr = remainder;
      rs = rst;
      c  = ce;
      nx.v = in_valid;
      nx.z = (divisor == '0);
      if (divisor == '0) begin
         nx.q = '1;
         nx.r = dividend[D-1:0];
      end else begin
         nx.q = dividend / divisor;
         nx.r = D'(dividend % divisor);
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         for (int k = 0; k <= N; k++) line[k] = '0;
         chk("rst_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_quot", {16'd0, quotient}, 32'd0);
         chk("rst_rem", {16'd0, remainder}, 32'd0);
`ifdef DIV_ZERO_DET_EN
         chk("rst_dz", {31'd0, dz}, 32'd0);
`endif
      end else if (c) begin
         for (int k = N; k > 0; k--) line[k] = line[k-1];
         line[0] = nx;
         chk("valid", {31'd0, out_valid}, {31'd0, line[N].v});
         if (line[N].v) begin
            nvalid++;
            chk("quot", {16'd0, quotient}, {16'd0, line[N].q});
            chk("rem", {16'd0, remainder}, {16'd0, line[N].r});
`ifdef DIV_ZERO_DET_EN
            chk("dz", {31'd0, dz}, {31'd0, line[N].z});
`endif
         end
      end else begin
         chk("stall_valid", {31'd0, out_valid}, {31'd0, pv});
         chk("stall_quot", {16'd0, quotient}, {16'd0, pq});
         chk("stall_rem", {16'd0, remainder}, {16'd0, pr});
      end
   endtask

   task automatic issue(input logic [N-1:0] a, input logic [D-1:0] b);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      for (int k = 0; k <= N; k++) line[k] = '0;

      // Reset with ce low must still clear everything.
      repeat (3) tick();
      rst = 1'b1;
      ce  = 1'b1;
      tick();

      // 100 / 7 = 14 r 2, valid for exactly one cycle after 16 advancing edges.
      issue(16'd100, 16'd7);
      repeat (15) tick();
      tick();
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_quot", {16'd0, quotient}, 32'd14);
      chk("basic_rem", {16'd0, remainder}, 32'd2);
      tick();
      chk("basic_one_cycle", {31'd0, out_valid}, 32'd0);

      // Divide by zero.
      issue(16'hABCD, 16'h0000);
      repeat (15) tick();
      chk("dz_early", {31'd0, out_valid}, 32'd0);
      tick();
      chk("dz_quot", {16'd0, quotient}, 32'h0000_FFFF);
      chk("dz_rem", {16'd0, remainder}, 32'h0000_ABCD);
`ifdef DIV_ZERO_DET_EN
      chk("dz_flag", {31'd0, dz}, 32'd1);
`endif
      repeat (2) tick();

      // Streaming: 40 back-to-back operations.
      mark = nvalid;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) begin
            dividend = 16'hFFFF;
            divisor  = 16'h0001;
         end else if (i == 17) begin
            dividend = 16'd5;
            divisor  = 16'hFFFF;
         end else if (i == 29) begin
            dividend = 16'd1234;
            divisor  = 16'd0;
         end else begin
            dividend = N'($urandom);
            divisor  = (i % 2 == 0) ? D'($urandom_range(1, 255)) : D'($urandom_range(1, 65535));
         end
         tick();
      end
      in_valid = 1'b0;
      repeat (N + 2) tick();
      chk("stream_count", nvalid - mark, 32'd40);

      // Stall: 8 operations in flight, ce low for 5 cycles with junk presented at the inputs.
      mark = nvalid;
      for (int i = 0; i < 8; i++) issue(N'(1000 + 977 * i), D'(3 + 11 * i));
      repeat (4) tick();
      ce = 1'b0;
      in_valid = 1'b1;
      dividend = 16'h1111;
      divisor  = 16'h0002;
      repeat (5) tick();
      in_valid = 1'b0;
      ce = 1'b1;
      repeat (3) tick();
      chk("stall_not_yet", {31'd0, out_valid}, 32'd0);
      repeat (N) tick();
      chk("stall_count", nvalid - mark, 32'd8);

      // Reset mid-flight discards in-flight operations.
      for (int i = 0; i < 10; i++) issue(N'(500 + 31 * i), D'(1 + i));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mark = nvalid;
      issue(16'd50, 16'd8);
      repeat (15) tick();
      chk("rst_discard", nvalid - mark, 32'd0);
      tick();
      chk("rst_new_valid", {31'd0, out_valid}, 32'd1);
      chk("rst_new_quot", {16'd0, quotient}, 32'd6);
      chk("rst_new_rem", {16'd0, remainder}, 32'd2);
      repeat (3) tick();
      chk("rst_total", nvalid - mark, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_div.md
PIPELINED_DIV -- requirements
Module: pipelined_div

Interface
REQ-001 SHALL have parameter N, default 16: dividend and quotient width.
REQ-002 SHALL have parameter D, default 16: divisor and remainder width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ce, input, 1 bit: pipeline advance enable.
REQ-006 SHALL have port in_valid, input, 1 bit: dividend and divisor are valid this cycle.
REQ-007 SHALL have port dividend, input, N bits: unsigned numerator.
REQ-008 SHALL have port divisor, input, D bits: unsigned denominator.
REQ-009 SHALL have port out_valid, output, 1 bit: quotient and remainder are valid this cycle.
REQ-010 SHALL have port quotient, output, N bits: unsigned floor(dividend/divisor).
REQ-011 SHALL have port remainder, output, D bits: unsigned dividend mod divisor.
REQ-012 SHALL have port dz, output, 1 bit, present only with DIV_ZERO_DET_EN: the result was computed from divisor == 0.

Function
REQ-013 SHALL implement restoring division as N registered stages, one quotient bit per stage, MSB first.
REQ-014 Stage k (0..N-1) SHALL form a (D+1)-bit trial value {partial remainder, dividend bit N-1-k}.
- If trial >= divisor: stage k SHALL subtract divisor and set the quotient bit to 1.
- Otherwise: stage k SHALL keep the trial value and set the quotient bit to 0.
REQ-015 Each stage SHALL carry forward its own copy of divisor, the unconsumed dividend bits, the accumulated quotient bits and a valid bit, so that operands in different stages never interfere.
REQ-016 Latency SHALL be exactly N advancing cycles.
- Operands sampled on the edge where ce=1 and in_valid=1 appear with out_valid=1 after N further edges with ce=1.
REQ-017 Throughput SHALL be one operation per advancing cycle, with back-to-back in_valid accepted and no bubbles inserted.
REQ-018 When ce=0, every pipeline register, including valid bits and outputs, SHALL hold its value, and in_valid/operands SHALL be ignored.
REQ-019 When in_valid=0 on an advancing cycle, a bubble (valid=0) SHALL enter stage 0 and emerge N cycles later as out_valid=0.
REQ-020 quotient, remainder and dz SHALL be registered outputs, changing only on advancing edges.
- Their values while out_valid=0 are don't-care, except after reset (REQ-024).
REQ-021 Divisor == 0 SHALL yield quotient = all ones (2^N-1) and remainder = dividend[D-1:0] (zero-extended if D > N), without special-casing the datapath.
REQ-022 The result SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for all divisor != 0.
REQ-023 The remainder SHALL fit in D bits; the internal (D+1)th bit is needed only for the comparison.

Reset
REQ-024 On a rising clk edge with rst=0, regardless of ce:
- all stage valid bits SHALL clear to 0;
- out_valid, quotient, remainder and dz SHALL be 0.
REQ-025 In-flight operations at reset SHALL be discarded, with no out_valid produced for them after reset release.
REQ-026 The first operation accepted on or after the first edge with rst=1 SHALL appear N advancing cycles later.

Configuration
REQ-027 The macro DIV_ZERO_DET_EN SHALL control divide-by-zero detection.
- Defined: the dz port exists, and a per-stage flag (divisor == 0 at entry) travels with its operation and drives dz aligned with out_valid.
- Undefined: no dz port and no flag registers; quotient and remainder behaviour is unchanged (REQ-021).

Verification
REQ-028 Basic divide (N=D=16): dividend=100, divisor=7, in_valid=1 for one cycle, ce=1 -> 16 cycles later out_valid=1, quotient=14, remainder=2, dz=0, asserted for exactly one cycle.
REQ-029 Divide by zero, with DIV_ZERO_DET_EN defined and undefined: dividend=0xABCD, divisor=0 -> quotient=0xFFFF, remainder=0xABCD, dz=1 (macro defined).
REQ-030 Streaming: 40 back-to-back random operations including 0xFFFF/1 (q=0xFFFF, r=0) and 5/0xFFFF (q=0, r=5) -> 40 consecutive out_valid cycles, each matching the reference model in order.
REQ-031 Stall: ce=0 for 5 cycles with 8 operations in flight -> outputs frozen during the stall, all 8 results correct and delivered 5 cycles late.
REQ-032 Reset mid-flight: rst=0 for one cycle with 10 operations in flight, then a new operation 50/8 -> no out_valid for the discarded operations, then quotient=6, remainder=2 exactly 16 cycles after acceptance.
